// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and default sizing for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, HOLD, HOLD_REDIR} state_t;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_STALL_TIMEOUT = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : (inc && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/freeze sequencing for a 5-stage pipeline with perf counters and stall watchdog
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_from_ID,
  input  logic             i_branch_taken_EX,
  input  logic             i_dmem_busy,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_redirect,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_deadlock
);
  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  state_t          state;
  logic [CW-1:0]   consec;
  logic            freeze, redir, stall_now;
  // Reset forces normal actions, so every applied action is gated by !i_rst
  always_comb begin
    freeze       = i_dmem_busy && !i_rst;
    redir        = !i_rst && !i_dmem_busy && (i_branch_taken_EX || state == HOLD_REDIR);
    stall_now    = !i_rst && !i_dmem_busy && !redir && i_stall_from_ID;
    o_pc_en      = !freeze && !stall_now;
    o_ifid_en    = !freeze && !stall_now;
    o_ifid_flush = redir;
    o_idex_en    = !freeze;
    o_idex_flush = redir || stall_now;
    o_exmem_en   = !freeze;
    o_memwb_en   = !freeze;
    o_redirect   = redir;
  end
  always_ff @(posedge i_clk) begin
    state      <= i_rst ? RUN
                : i_dmem_busy ? ((state == HOLD_REDIR || i_branch_taken_EX) ? HOLD_REDIR : HOLD)
                : RUN;
    consec     <= i_rst ? '0
                : stall_now ? ((consec == CW'(STALL_TIMEOUT)) ? consec : consec + CW'(1))
                : freeze ? consec : '0;
    o_deadlock <= !i_rst && (o_deadlock || (stall_now && consec == CW'(STALL_TIMEOUT - 1)));
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(i_clk), .rst(i_rst), .inc(stall_now), .clr(1'b0), .q(o_stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(i_clk), .rst(i_rst), .inc(redir), .clr(1'b0), .q(o_flush_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of stage control, counters, watchdog and reset behaviour
module tb_pipeline_ctrl;
  logic clk = 0, rst = 1, stall = 0, branch = 0, busy = 0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, redirect, deadlock;
  logic pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exmem_en4, memwb_en4, redirect4, deadlock4;
  logic [31:0] stall_cycles, flush_count;
  logic [3:0]  stall_cycles4, flush_count4;
  logic [7:0]  ctl;
  int checks = 0, errors = 0;
  int exp_stall = 0, exp_flush = 0;
  localparam logic [7:0] NORMAL = 8'b11010110;
  localparam logic [7:0] STALL  = 8'b00011110;
  localparam logic [7:0] REDIR  = 8'b11111111;
  localparam logic [7:0] FREEZE = 8'b00000000;

  always #5 clk = ~clk;
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, redirect};

  pipeline_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_stall_from_ID(stall), .i_branch_taken_EX(branch), .i_dmem_busy(busy),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush), .o_idex_en(idex_en),
    .o_idex_flush(idex_flush), .o_exmem_en(exmem_en), .o_memwb_en(memwb_en), .o_redirect(redirect),
    .o_stall_cycles(stall_cycles), .o_flush_count(flush_count), .o_deadlock(deadlock)
  );
  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_stall_from_ID(stall), .i_branch_taken_EX(branch), .i_dmem_busy(busy),
    .o_pc_en(pc_en4), .o_ifid_en(ifid_en4), .o_ifid_flush(ifid_flush4), .o_idex_en(idex_en4),
    .o_idex_flush(idex_flush4), .o_exmem_en(exmem_en4), .o_memwb_en(memwb_en4), .o_redirect(redirect4),
    .o_stall_cycles(stall_cycles4), .o_flush_count(flush_count4), .o_deadlock(deadlock4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 1; branch = 1; busy = 0;
    #1;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, NORMAL); end
    step();
    checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cycles); end
    checks++; if (flush_count !== 0) begin errors++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_count); end
    checks++; if (deadlock !== 0) begin errors++; $display("FAIL reset_deadlock got=%b exp=0", deadlock); end
    rst = 0; stall = 0; branch = 0;
    #1;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL normal_ctl got=%b exp=%b", ctl, NORMAL); end
    step();
    exp_stall = 0; exp_flush = 0;
  endtask

  task automatic test_stall();
    stall = 1;
    #1;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL stall_ctl got=%b exp=%b", ctl, STALL); end
    step(); exp_stall++;
    stall = 0;
    #1;
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall); end
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL stall_release_ctl got=%b exp=%b", ctl, NORMAL); end
    step();
  endtask

  task automatic test_branch_stall();
    stall = 1; branch = 1;
    #1;
    checks++; if (ctl !== REDIR) begin errors++; $display("FAIL branch_stall_ctl got=%b exp=%b", ctl, REDIR); end
    step(); exp_flush++;
    stall = 0; branch = 0;
    #1;
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL branch_stall_scnt got=%0d exp=%0d", stall_cycles, exp_stall); end
    checks++; if (flush_count !== 32'(exp_flush)) begin errors++; $display("FAIL branch_flush_cnt got=%0d exp=%0d", flush_count, exp_flush); end
    step();
  endtask

  task automatic test_freeze_redirect();
    for (int i = 0; i < 3; i++) begin
      busy = 1; branch = (i == 1); stall = (i == 2);
      #1;
      checks++; if (ctl !== FREEZE) begin errors++; $display("FAIL freeze_ctl cyc=%0d got=%b exp=%b", i, ctl, FREEZE); end
      step();
    end
    busy = 0; branch = 0; stall = 1;
    #1;
    checks++; if (ctl !== REDIR) begin errors++; $display("FAIL pending_redir_ctl got=%b exp=%b", ctl, REDIR); end
    step(); exp_flush++;
    stall = 0;
    #1;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL post_redir_ctl got=%b exp=%b", ctl, NORMAL); end
    checks++; if (flush_count !== 32'(exp_flush)) begin errors++; $display("FAIL freeze_flush_cnt got=%0d exp=%0d", flush_count, exp_flush); end
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL freeze_stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall); end
    step();
  endtask

  task automatic test_deadlock();
    for (int i = 0; i < 15; i++) begin stall = 1; step(); exp_stall++; end
    stall = 0; step();
    checks++; if (deadlock !== 0) begin errors++; $display("FAIL deadlock_15 got=%b exp=0", deadlock); end
    for (int i = 0; i < 16; i++) begin
      stall = 1; step(); exp_stall++;
      if (i == 14) begin
        checks++; if (deadlock !== 0) begin errors++; $display("FAIL deadlock_early got=%b exp=0", deadlock); end
      end
    end
    checks++; if (deadlock !== 1) begin errors++; $display("FAIL deadlock_16 got=%b exp=1", deadlock); end
    stall = 0; step(); step();
    checks++; if (deadlock !== 1) begin errors++; $display("FAIL deadlock_sticky got=%b exp=1", deadlock); end
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL deadlock_scnt got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_freeze_hold();
    rst = 1; step(); rst = 0; exp_stall = 0; exp_flush = 0;
    checks++; if (deadlock !== 0) begin errors++; $display("FAIL deadlock_reset got=%b exp=0", deadlock); end
    for (int i = 0; i < 10; i++) begin stall = 1; step(); exp_stall++; end
    busy = 1; step(); busy = 0;
    for (int i = 0; i < 6; i++) begin
      stall = 1; step(); exp_stall++;
      if (i == 4) begin
        checks++; if (deadlock !== 0) begin errors++; $display("FAIL hold_early got=%b exp=0", deadlock); end
      end
    end
    stall = 0;
    checks++; if (deadlock !== 1) begin errors++; $display("FAIL hold_consec got=%b exp=1", deadlock); end
    step();
  endtask

  task automatic test_saturate();
    rst = 1; step(); rst = 0; exp_stall = 0;
    for (int i = 0; i < 20; i++) begin stall = 1; step(); exp_stall++; end
    stall = 0;
    checks++; if (stall_cycles4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cycles4); end
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL sat_cnt32 got=%0d exp=%0d", stall_cycles, exp_stall); end
    step();
    checks++; if (stall_cycles4 !== 4'd15) begin errors++; $display("FAIL sat_nowrap got=%0d exp=15", stall_cycles4); end
  endtask

  task automatic test_reset_redir();
    busy = 1; branch = 1; step(); branch = 0; step();
    rst = 1; busy = 0;
    #1;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL rst_redir_ctl got=%b exp=%b", ctl, NORMAL); end
    step();
    rst = 0;
    #1;
    checks++; if (redirect !== 0) begin errors++; $display("FAIL rst_redir_cancel got=%b exp=0", redirect); end
    step();
    checks++; if (redirect !== 0) begin errors++; $display("FAIL rst_redir_late got=%b exp=0", redirect); end
    checks++; if (flush_count !== 0) begin errors++; $display("FAIL rst_redir_fcnt got=%0d exp=0", flush_count); end
    checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL rst_redir_scnt got=%0d exp=0", stall_cycles); end
  endtask

  initial begin
    step();
    test_reset();
    test_stall();
    test_branch_stall();
    test_freeze_redirect();
    test_deadlock();
    test_freeze_hold();
    test_saturate();
    test_reset_redir();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
